pulse_stretch: RTL and testbench



---
 rtl/pulse_stretch_pkg.sv | 19 +
 rtl/pulse_stretch.sv | 123 ++++++++++++
 tb/tb_pulse_stretch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretch_pkg.sv
// Shared types and sizing helpers for pulse_stretch.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pstr_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches single-cycle event pulses into registered high/low windows of fixed width.
// Define PULSE_STRETCH_QUEUE_EN to queue events arriving while a pulse is in flight.
module pulse_stretch
    import pulse_stretch_pkg::*;
#(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 4,
    parameter int unsigned QUEUE_DEPTH = 7,
    parameter logic        INIT_VALUE  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    output logic sig_o,
    output logic busy_o,
    output logic ovf_o
);

    localparam int unsigned CW = cnt_width(max_u(HIGH_CYCLES, LOW_CYCLES));
    localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);

    pstr_state_e   state;
    logic [CW-1:0] cnt;
    logic          have_work;
    logic          start;
    logic          drop;

`ifdef PULSE_STRETCH_QUEUE_EN
    localparam int unsigned PW = cnt_width(QUEUE_DEPTH);
    localparam logic [PW-1:0] DEPTH = PW'(QUEUE_DEPTH);

    logic [PW-1:0] pending;
    logic [PW-1:0] pending_d;
    logic          from_queue;
    logic          accept;
`else
    // Depth has no meaning without the queue.
    logic unused_depth;
    assign unused_depth = (QUEUE_DEPTH == 0);
`endif

    // Event consumption and queue accounting for the current cycle.
    always_comb begin
        have_work = pulse_i;
        drop      = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
        have_work = pulse_i || (pending != '0);
`endif
        start = have_work && ((state == IDLE) || ((state == GAP) && (cnt == '0)));
`ifdef PULSE_STRETCH_QUEUE_EN
        pending_d  = pending;
        from_queue = start && (pending != '0);
        accept     = pulse_i && !(start && (pending == '0));
        drop       = accept && !from_queue && (pending == DEPTH);
        if (from_queue && !accept) begin
            pending_d = pending - PW'(1);
        end else if (accept && !from_queue && !drop) begin
            pending_d = pending + PW'(1);
        end
`else
        drop = pulse_i && !start;
`endif
    end

    // Pulse FSM; sig_o and busy_o are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sig_o  <= INIT_VALUE;
            busy_o <= 1'b0;
            ovf_o  <= 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending <= '0;
`endif
        end else begin
            ovf_o <= ovf_o | drop;
`ifdef PULSE_STRETCH_QUEUE_EN
            pending <= pending_d;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= HIGH;
                        cnt    <= HIGH_LOAD;
                        sig_o  <= ~INIT_VALUE;
                        busy_o <= 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        state <= GAP;
                        cnt   <= LOW_LOAD;
                        sig_o <= INIT_VALUE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (start) begin
                        state <= HIGH;
                        cnt   <= HIGH_LOAD;
                        sig_o <= ~INIT_VALUE;
                    end else begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    sig_o  <= INIT_VALUE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: vector table, corner sequences, random traffic against a schedule model,
// and an end-to-end count through a two-flop synchronizer in a second clock domain.
`timescale 1ns/1ps
module tb_pulse_stretch;

    localparam int unsigned HA = 4;
    localparam int unsigned LA = 4;
    localparam int unsigned QA = 7;
    localparam logic        IA = 1'b0;
    localparam logic        ACT_A = ~IA;
    localparam int unsigned HB = 3;
    localparam int unsigned LB = 2;
    localparam int unsigned QB = 2;
    localparam logic        IB = 1'b1;
`ifdef PULSE_STRETCH_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    typedef struct {
        bit   p;
        bit   r;
        logic sig;
        logic busy;
        logic ovf;
    } vec_t;

    logic clk   = 1'b0;
    logic clk2  = 1'b0;
    logic rst   = 1'b1;
    logic pulse = 1'b0;
    logic sig_a, busy_a, ovf_a;
    logic sig_b, busy_b, ovf_b;

    int total = 0;
    int bad   = 0;
    int m     = 0;
    int accepted_a = 0;
    bit has_last [2];
    int last_s   [2];
    bit movf     [2];
    vec_t tbl [11];

    logic [1:0] sync_ff = 2'b00;
    logic       sync_q  = 1'b0;
    int         sync_rises = 0;

    always #5 clk = ~clk;
    always #6 clk2 = ~clk2;

    pulse_stretch #(.HIGH_CYCLES(HA), .LOW_CYCLES(LA), .QUEUE_DEPTH(QA), .INIT_VALUE(IA)) u_a (
        .clk(clk), .rst(rst), .pulse_i(pulse), .sig_o(sig_a), .busy_o(busy_a), .ovf_o(ovf_a)
    );

    pulse_stretch #(.HIGH_CYCLES(HB), .LOW_CYCLES(LB), .QUEUE_DEPTH(QB), .INIT_VALUE(IB)) u_b (
        .clk(clk), .rst(rst), .pulse_i(pulse), .sig_o(sig_b), .busy_o(busy_b), .ovf_o(ovf_b)
    );

    // Far-end synchronizer on an unrelated clock; counts rising edges it delivers.
    always @(posedge clk2) begin
        sync_ff <= {sync_ff[0], sig_a};
        sync_q  <= sync_ff[1];
        if (sync_ff[1] && !sync_q) sync_rises <= sync_rises + 1;
    end

    function automatic int hc(input int i);
        return (i == 0) ? int'(HA) : int'(HB);
    endfunction

    function automatic int per(input int i);
        return (i == 0) ? int'(HA + LA) : int'(HB + LB);
    endfunction

    function automatic int qd(input int i);
        return (i == 0) ? int'(QA) : int'(QB);
    endfunction

    function automatic logic init_of(input int i);
        return (i == 0) ? IA : IB;
    endfunction

    // Each accepted event owns the window [start, start+HIGH); queued starts sit exactly one period apart.
    function automatic logic exp_sig(input int i);
        int s;
        bit act;
        act = 1'b0;
        if (has_last[i]) begin
            s = last_s[i];
            if (s > m) s = s - ((s - m + per(i) - 1) / per(i)) * per(i);
            act = (m >= s) && (m < s + hc(i));
        end
        return act ^ init_of(i);
    endfunction

    function automatic logic exp_busy(input int i);
        return has_last[i] && (m < last_s[i] + per(i));
    endfunction

    function automatic void model_step(input int i, input bit p, input bit r);
        int s_new;
        int future;
        bit take;
        if (r) begin
            has_last[i] = 1'b0;
            movf[i]     = 1'b0;
            return;
        end
        if (!p) return;
        s_new = m + 1;
        if (has_last[i] && (last_s[i] + per(i) > s_new)) s_new = last_s[i] + per(i);
        future = 0;
        if (has_last[i] && (last_s[i] > m + 1)) future = (last_s[i] - m - 2) / per(i) + 1;
        take = (s_new == m + 1) || (QEN && (future < qd(i)));
        if (take) begin
            has_last[i] = 1'b1;
            last_s[i]   = s_new;
            if (i == 0) accepted_a++;
        end else begin
            movf[i] = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m);
        end
    endtask

    // One cycle: check both DUTs against the model, then drive inputs for the next edge.
    task automatic step(input bit p, input bit r);
        @(negedge clk);
        chk("model sig_a", sig_a, exp_sig(0));
        chk("model busy_a", busy_a, exp_busy(0));
        chk("model ovf_a", ovf_a, movf[0]);
        chk("model sig_b", sig_b, exp_sig(1));
        chk("model busy_b", busy_b, exp_busy(1));
        chk("model ovf_b", ovf_b, movf[1]);
        pulse = p;
        rst   = r;
        model_step(0, p, r);
        model_step(1, p, r);
        m++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    initial begin
        int edges;
        int busy_last;
        int busy_low;
        int first_ovf;
        int acc0;
        int rise0;
        int div;
        logic prev;

        for (int k = 0; k < 11; k++) begin
            tbl[k].p    = (k == 0);
            tbl[k].r    = 1'b0;
            tbl[k].sig  = (k >= 1 && k <= 4) ? ACT_A : IA;
            tbl[k].busy = (k >= 1 && k <= 8);
            tbl[k].ovf  = 1'b0;
        end
        has_last[0] = 1'b0; has_last[1] = 1'b0;
        movf[0] = 1'b0; movf[1] = 1'b0;
        last_s[0] = 0; last_s[1] = 0;

        repeat (3) step(1'b0, 1'b1);
        idle(2);
        chk("reset sig_b level", sig_b, IB);

        // Single event on the default-parameter instance.
        for (int k = 0; k < 11; k++) begin
            step(tbl[k].p, tbl[k].r);
            chk("vec sig_a", sig_a, tbl[k].sig);
            chk("vec busy_a", busy_a, tbl[k].busy);
            chk("vec ovf_a", ovf_a, tbl[k].ovf);
        end

        // Three back-to-back events.
        idle(5);
        prev = sig_a; edges = 0; busy_last = -1;
        for (int k = 0; k < 40; k++) begin
            step(k < 3, 1'b0);
            if (sig_a !== IA && prev === IA) edges++;
            prev = sig_a;
            if (busy_a) busy_last = k;
        end
        chk("b2b pulse count", edges, QEN ? 3 : 1);
        chk("b2b busy end", busy_last, QEN ? 24 : 8);
        chk("b2b ovf", ovf_a, QEN ? 0 : 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk("reset clears ovf", ovf_a, 1'b0);

        // Overflow on the shallow-queue instance.
        idle(3);
        prev = sig_b; edges = 0; first_ovf = -1;
        for (int k = 0; k < 30; k++) begin
            step(k < 5, 1'b0);
            if (sig_b !== IB && prev === IB) edges++;
            prev = sig_b;
            if (ovf_b === 1'b1 && first_ovf < 0) first_ovf = k;
        end
        chk("ovf pulse count", edges, QEN ? 3 : 1);
        chk("ovf first cycle", first_ovf, QEN ? 4 : 2);
        chk("ovf sticky", ovf_b, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);

        // Event on the last gap cycle restarts without an idle cycle.
        idle(3);
        prev = sig_a; edges = 0; busy_last = -1; busy_low = 0;
        for (int k = 0; k < 24; k++) begin
            step(k == 0 || k == 8, 1'b0);
            if (sig_a !== IA && prev === IA) edges++;
            prev = sig_a;
            if (busy_a) busy_last = k;
            if (k >= 1 && k <= 16 && busy_a !== 1'b1) busy_low++;
            if (k == 9) chk("gap-end sig", sig_a, ACT_A);
        end
        chk("gap-end no idle", busy_low, 0);
        chk("gap-end count", edges, 2);
        chk("gap-end busy end", busy_last, 16);

        // Reset during a pulse with events queued behind it.
        idle(3);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("mid-reset sig_a", sig_a, IA);
        chk("mid-reset busy_a", busy_a, 1'b0);
        chk("mid-reset ovf_a", ovf_a, 1'b0);
        chk("mid-reset sig_b", sig_b, IB);
        chk("mid-reset busy_b", busy_b, 1'b0);
        prev = sig_a; edges = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0);
            if (sig_a !== IA && prev === IA) edges++;
            prev = sig_a;
        end
        chk("mid-reset queue flushed", edges, 0);

        // Random traffic at several densities, also counted through the far-end synchronizer.
        idle(10);
        acc0  = accepted_a;
        rise0 = sync_rises;
        for (int seg = 0; seg < 3; seg++) begin
            div = (seg == 0) ? 2 : ((seg == 1) ? 6 : 25);
            for (int k = 0; k < 500; k++) step($urandom_range(0, div - 1) == 0, 1'b0);
        end
        idle(40);
        chk("sync edge count", sync_rises - rise0, accepted_a - acc0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) step($urandom_range(0, 2) == 0, $urandom_range(0, 49) == 0);
        step(1'b0, 1'b1);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
